// File: rtl/oled_cmd_receiver.sv
// SPI command/data receiver for an OLED controller: synchronizes pad inputs, assembles bytes and decodes configuration commands.
// Optional sdout echo of the previously completed byte is enabled by defining OLED_CMD_RX_ECHO_EN.
module oled_cmd_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       sclk,
    input  logic       sdin,
    input  logic       dc,
    input  logic       res_n,
    output logic       sdout,
    output logic       disp_on,
    output logic       charge_pump_en,
    output logic [5:0] mux_ratio,
    output logic [5:0] disp_offset,
    output logic [5:0] start_line,
    output logic [1:0] addr_mode,
    output logic [7:0] data_byte,
    output logic       data_valid,
    output logic [7:0] cmd_byte,
    output logic       cmd_valid,
    output logic       cmd_err
);

    typedef enum logic {IDLE, PARAM} state_t;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdin_sync, dc_sync, res_sync;
    logic cs_s, sclk_s, sdin_s, dc_s, res_s;
    logic sclk_d, sclk_rise, byte_done;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic [7:0] rx_byte;

    state_t     state, state_nxt;
    logic [7:0] opcode, opcode_nxt;
    logic       disp_on_nxt, cp_nxt;
    logic [5:0] mux_nxt, offset_nxt, line_nxt;
    logic [1:0] mode_nxt;
    logic [7:0] data_nxt, cmd_nxt;
    logic       dv_nxt, cv_nxt, ce_nxt;

    // Pad synchronizers; idle levels keep cs_n/sclk/res_n deasserted-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            sclk_sync <= '1;
            res_sync  <= '1;
            sdin_sync <= '0;
            dc_sync   <= '0;
            sclk_d    <= 1'b1;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            res_sync  <= {res_sync[SYNC_STAGES-2:0], res_n};
            sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
            sclk_d    <= sclk_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sdin_s    = sdin_sync[SYNC_STAGES-1];
    assign dc_s      = dc_sync[SYNC_STAGES-1];
    assign res_s     = res_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d & ~cs_s;
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign rx_byte   = {shift, sdin_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 3'd0;
            shift   <= 7'd0;
        end else if (!res_s || cs_s) begin
            bit_cnt <= 3'd0;
        end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            shift   <= {shift[5:0], sdin_s};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            opcode         <= 8'h00;
            disp_on        <= 1'b0;
            charge_pump_en <= 1'b0;
            mux_ratio      <= 6'd63;
            disp_offset    <= 6'd0;
            start_line     <= 6'd0;
            addr_mode      <= 2'd2;
            data_byte      <= 8'h00;
            cmd_byte       <= 8'h00;
            data_valid     <= 1'b0;
            cmd_valid      <= 1'b0;
            cmd_err        <= 1'b0;
        end else begin
            state          <= state_nxt;
            opcode         <= opcode_nxt;
            disp_on        <= disp_on_nxt;
            charge_pump_en <= cp_nxt;
            mux_ratio      <= mux_nxt;
            disp_offset    <= offset_nxt;
            start_line     <= line_nxt;
            addr_mode      <= mode_nxt;
            data_byte      <= data_nxt;
            cmd_byte       <= cmd_nxt;
            data_valid     <= dv_nxt;
            cmd_valid      <= cv_nxt;
            cmd_err        <= ce_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        opcode_nxt  = opcode;
        disp_on_nxt = disp_on;
        cp_nxt      = charge_pump_en;
        mux_nxt     = mux_ratio;
        offset_nxt  = disp_offset;
        line_nxt    = start_line;
        mode_nxt    = addr_mode;
        data_nxt    = data_byte;
        cmd_nxt     = cmd_byte;
        dv_nxt      = 1'b0;
        cv_nxt      = 1'b0;
        ce_nxt      = 1'b0;
        if (byte_done && dc_s) begin
            data_nxt = rx_byte;
            dv_nxt   = 1'b1;
        end else if (byte_done) begin
            cmd_nxt = rx_byte;
            cv_nxt  = 1'b1;
            case (state)
                IDLE: begin
                    if (rx_byte == 8'hAE) begin
                        disp_on_nxt = 1'b0;
                    end else if (rx_byte == 8'hAF) begin
                        disp_on_nxt = 1'b1;
                    end else if (rx_byte[7:6] == 2'b01) begin
                        line_nxt = rx_byte[5:0];
                    end else if (rx_byte == 8'hA8 || rx_byte == 8'hD3 ||
                                 rx_byte == 8'h8D || rx_byte == 8'h20) begin
                        opcode_nxt = rx_byte;
                        state_nxt  = PARAM;
                    end else begin
                        cv_nxt = 1'b0;
                        ce_nxt = 1'b1;
                    end
                end
                PARAM: begin
                    state_nxt = IDLE;
                    case (opcode)
                        8'hA8: begin
                            if (rx_byte[5:0] >= 6'd15) mux_nxt = rx_byte[5:0];
                            else begin
                                cv_nxt = 1'b0;
                                ce_nxt = 1'b1;
                            end
                        end
                        8'hD3: offset_nxt = rx_byte[5:0];
                        8'h8D: cp_nxt = rx_byte[2];
                        default: begin
                            if (rx_byte[1:0] != 2'd3) mode_nxt = rx_byte[1:0];
                            else begin
                                cv_nxt = 1'b0;
                                ce_nxt = 1'b1;
                            end
                        end
                    endcase
                end
                default: state_nxt = IDLE;
            endcase
        end
        // OLED reset pin wins over any byte completing in the same cycle.
        if (!res_s) begin
            state_nxt   = IDLE;
            opcode_nxt  = 8'h00;
            disp_on_nxt = 1'b0;
            cp_nxt      = 1'b0;
            mux_nxt     = 6'd63;
            offset_nxt  = 6'd0;
            line_nxt    = 6'd0;
            mode_nxt    = 2'd2;
            data_nxt    = 8'h00;
            cmd_nxt     = 8'h00;
            dv_nxt      = 1'b0;
            cv_nxt      = 1'b0;
            ce_nxt      = 1'b0;
        end
    end

`ifdef OLED_CMD_RX_ECHO_EN
    logic       cs_d, cs_fall, sclk_fall;
    logic [7:0] last_byte, echo_sh;

    assign cs_fall   = ~cs_s & cs_d;
    assign sclk_fall = ~sclk_s & sclk_d & ~cs_s;

    // Reload at each byte boundary so back-to-back bytes in one frame echo correctly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_d      <= 1'b1;
            last_byte <= 8'h00;
            echo_sh   <= 8'h00;
        end else begin
            cs_d <= cs_s;
            if (!res_s) begin
                last_byte <= 8'h00;
                echo_sh   <= 8'h00;
            end else begin
                if (byte_done) last_byte <= rx_byte;
                if (cs_fall) echo_sh <= last_byte;
                else if (sclk_fall) echo_sh <= (bit_cnt == 3'd0) ? last_byte : {echo_sh[6:0], 1'b0};
            end
        end
    end

    assign sdout = echo_sh[7];
`else
    assign sdout = 1'b0;
`endif

endmodule

// File: tb/tb_oled_cmd_receiver.sv
// Directed bench for oled_cmd_receiver: SPI frames with hand-computed decoder results.
// Define OLED_CMD_RX_ECHO_EN for both files to exercise the sdout echo path.
module tb_oled_cmd_receiver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n = 1'b1;
    logic       sclk = 1'b0;
    logic       sdin = 1'b0;
    logic       dc = 1'b0;
    logic       res_n = 1'b1;
    logic       sdout;
    logic       disp_on, charge_pump_en;
    logic [5:0] mux_ratio, disp_offset, start_line;
    logic [1:0] addr_mode;
    logic [7:0] data_byte, cmd_byte;
    logic       data_valid, cmd_valid, cmd_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int n_dv = 0, n_cv = 0, n_ce = 0, n_both = 0;

    oled_cmd_receiver #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .sdin(sdin), .dc(dc),
        .res_n(res_n), .sdout(sdout), .disp_on(disp_on), .charge_pump_en(charge_pump_en),
        .mux_ratio(mux_ratio), .disp_offset(disp_offset), .start_line(start_line),
        .addr_mode(addr_mode), .data_byte(data_byte), .data_valid(data_valid),
        .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Each negedge a pulse is high counts once, so a stretched pulse counts twice.
    always @(negedge clk) begin
        if (data_valid) n_dv++;
        if (cmd_valid) n_cv++;
        if (cmd_err) n_ce++;
        if (cmd_valid && cmd_err) n_both++;
    end

    // rst_kind: 0 none, 1 pulse rst_n, 2 pulse res_n, after the sent bits while cs_n is still low.
    task automatic send_byte(input logic [7:0] b, input logic d, input int nbits,
                             input int rst_kind, output logic [7:0] echo);
        echo = 8'h00;
        @(negedge clk);
        cs_n = 1'b0;
        dc = d;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sdin = b[7-i];
            repeat (5) @(negedge clk);
            echo[7-i] = sdout;
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (6) @(negedge clk);
        if (rst_kind == 1) begin
            rst_n = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
        end else if (rst_kind == 2) begin
            res_n = 1'b0;
            repeat (5) @(negedge clk);
            res_n = 1'b1;
        end
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic cmd(input logic [7:0] b);
        logic [7:0] e;
        send_byte(b, 1'b0, 8, 0, e);
    endtask

    task automatic test_reset;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total_cnt++; if (disp_on !== 1'b0) $display("FAIL reset_disp_on got %0h want 0", disp_on); else pass_cnt++;
        total_cnt++; if (charge_pump_en !== 1'b0) $display("FAIL reset_cp got %0h want 0", charge_pump_en); else pass_cnt++;
        total_cnt++; if (mux_ratio !== 6'd63) $display("FAIL reset_mux got %0d want 63", mux_ratio); else pass_cnt++;
        total_cnt++; if (disp_offset !== 6'd0) $display("FAIL reset_offset got %0d want 0", disp_offset); else pass_cnt++;
        total_cnt++; if (start_line !== 6'd0) $display("FAIL reset_line got %0d want 0", start_line); else pass_cnt++;
        total_cnt++; if (addr_mode !== 2'd2) $display("FAIL reset_mode got %0d want 2", addr_mode); else pass_cnt++;
        total_cnt++; if (data_byte !== 8'h00) $display("FAIL reset_data got %0h want 00", data_byte); else pass_cnt++;
        total_cnt++; if (cmd_byte !== 8'h00) $display("FAIL reset_cmd got %0h want 00", cmd_byte); else pass_cnt++;
        total_cnt++; if ({data_valid, cmd_valid, cmd_err, sdout} !== 4'b0) $display("FAIL reset_pulses got %b want 0000", {data_valid, cmd_valid, cmd_err, sdout}); else pass_cnt++;
    endtask

    task automatic test_init_seq;
        logic [7:0] seq [11] = '{8'hAE, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hAF};
        int cv0 = n_cv, ce0 = n_ce;
        foreach (seq[i]) cmd(seq[i]);
        total_cnt++; if (disp_on !== 1'b1) $display("FAIL init_disp_on got %0h want 1", disp_on); else pass_cnt++;
        total_cnt++; if (mux_ratio !== 6'd63) $display("FAIL init_mux got %0d want 63", mux_ratio); else pass_cnt++;
        total_cnt++; if (charge_pump_en !== 1'b1) $display("FAIL init_cp got %0h want 1", charge_pump_en); else pass_cnt++;
        total_cnt++; if (addr_mode !== 2'd0) $display("FAIL init_mode got %0d want 0", addr_mode); else pass_cnt++;
        total_cnt++; if ({disp_offset, start_line} !== 12'd0) $display("FAIL init_offset_line got %0h want 0", {disp_offset, start_line}); else pass_cnt++;
        total_cnt++; if (n_cv - cv0 !== 11) $display("FAIL init_cmd_valid got %0d want 11", n_cv - cv0); else pass_cnt++;
        total_cnt++; if (n_ce - ce0 !== 0) $display("FAIL init_cmd_err got %0d want 0", n_ce - ce0); else pass_cnt++;
        total_cnt++; if (cmd_byte !== 8'hAF) $display("FAIL init_cmd_byte got %0h want AF", cmd_byte); else pass_cnt++;
    endtask

    task automatic test_partial_frame;
        logic [7:0] e;
        int dv0 = n_dv, cv0 = n_cv, ce0 = n_ce;
        send_byte(8'hFF, 1'b0, 5, 0, e);
        send_byte(8'hA5, 1'b1, 8, 0, e);
        total_cnt++; if (n_dv - dv0 !== 1) $display("FAIL partial_data_valid got %0d want 1", n_dv - dv0); else pass_cnt++;
        total_cnt++; if (data_byte !== 8'hA5) $display("FAIL partial_data_byte got %0h want A5", data_byte); else pass_cnt++;
        total_cnt++; if ((n_cv - cv0) + (n_ce - ce0) !== 0) $display("FAIL partial_cmd_pulses got %0d want 0", (n_cv - cv0) + (n_ce - ce0)); else pass_cnt++;
    endtask

    task automatic test_params;
        int cv0 = n_cv, ce0 = n_ce;
        cmd(8'hA8); cmd(8'h05);
        total_cnt++; if (mux_ratio !== 6'd63) $display("FAIL mux_below_min got %0d want 63", mux_ratio); else pass_cnt++;
        total_cnt++; if (n_ce - ce0 !== 1) $display("FAIL mux_err_count got %0d want 1", n_ce - ce0); else pass_cnt++;
        cmd(8'h20); cmd(8'h03);
        total_cnt++; if (addr_mode !== 2'd0) $display("FAIL mode_3_rejected got %0d want 0", addr_mode); else pass_cnt++;
        cmd(8'hA8); cmd(8'h0F);
        total_cnt++; if (mux_ratio !== 6'd15) $display("FAIL mux_min_15 got %0d want 15", mux_ratio); else pass_cnt++;
        cmd(8'h7F);
        total_cnt++; if (start_line !== 6'd63) $display("FAIL start_line_7f got %0d want 63", start_line); else pass_cnt++;
        cmd(8'hD3); cmd(8'h25);
        total_cnt++; if (disp_offset !== 6'h25) $display("FAIL offset_25 got %0h want 25", disp_offset); else pass_cnt++;
        cmd(8'h00);
        total_cnt++; if (n_ce - ce0 !== 3) $display("FAIL param_err_total got %0d want 3", n_ce - ce0); else pass_cnt++;
        total_cnt++; if (n_cv - cv0 !== 7) $display("FAIL param_valid_total got %0d want 7", n_cv - cv0); else pass_cnt++;
        total_cnt++; if (cmd_byte !== 8'h00) $display("FAIL unknown_cmd_byte got %0h want 00", cmd_byte); else pass_cnt++;
    endtask

    task automatic test_data_in_param;
        logic [7:0] e;
        int dv0 = n_dv;
        cmd(8'h8D);
        send_byte(8'h3C, 1'b1, 8, 0, e);
        cmd(8'h10);
        total_cnt++; if (n_dv - dv0 !== 1) $display("FAIL param_data_valid got %0d want 1", n_dv - dv0); else pass_cnt++;
        total_cnt++; if (data_byte !== 8'h3C) $display("FAIL param_data_byte got %0h want 3C", data_byte); else pass_cnt++;
        total_cnt++; if (charge_pump_en !== 1'b0) $display("FAIL param_cp got %0h want 0", charge_pump_en); else pass_cnt++;
    endtask

    task automatic test_reset_midbyte;
        logic [7:0] e;
        int cnt0;
        for (int k = 1; k <= 2; k++) begin
            cmd(8'hA8); cmd(8'h0F);
            cmd(8'hAF);
            cnt0 = n_dv + n_cv + n_ce;
            send_byte(8'hAE, 1'b0, 4, k, e);
            total_cnt++; if (disp_on !== 1'b0) $display("FAIL midbyte_disp_on kind %0d got %0h want 0", k, disp_on); else pass_cnt++;
            total_cnt++; if (mux_ratio !== 6'd63) $display("FAIL midbyte_mux kind %0d got %0d want 63", k, mux_ratio); else pass_cnt++;
            total_cnt++; if (n_dv + n_cv + n_ce !== cnt0) $display("FAIL midbyte_pulses kind %0d got %0d want %0d", k, n_dv + n_cv + n_ce, cnt0); else pass_cnt++;
            cmd(8'hAF);
            total_cnt++; if (disp_on !== 1'b1) $display("FAIL after_reset_decode kind %0d got %0h want 1", k, disp_on); else pass_cnt++;
        end
    endtask

    task automatic test_echo;
        logic [7:0] e, want;
        send_byte(8'h5A, 1'b1, 8, 0, e);
        send_byte(8'hC3, 1'b1, 8, 0, e);
`ifdef OLED_CMD_RX_ECHO_EN
        want = 8'h5A;
`else
        want = 8'h00;
`endif
        total_cnt++; if (e !== want) $display("FAIL echo_sdout got %0h want %0h", e, want); else pass_cnt++;
        total_cnt++; if (data_byte !== 8'hC3) $display("FAIL echo_data_byte got %0h want C3", data_byte); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_init_seq();
        test_partial_frame();
        test_params();
        test_data_in_param();
        test_reset_midbyte();
        test_echo();
        total_cnt++; if (n_both !== 0) $display("FAIL valid_err_overlap got %0d want 0", n_both); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/oled_cmd_receiver.md
OLED_CMD_RECEIVER -- requirements
Module: oled_cmd_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops in each pad-input synchronizer (min 2).
REQ-002 SHALL have clk  input  1  system clock, and rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-004 SHALL have sclk  input  1  SPI serial clock, mode 0, asynchronous to clk.
REQ-005 SHALL have sdin  input  1  SPI data in, MSB first.
REQ-006 SHALL have dc  input  1  data/command select: 0 = command, 1 = display data.
REQ-007 SHALL have res_n  input  1  OLED reset pin, active-low, asynchronous to clk.
REQ-008 SHALL have sdout  output  1  SPI data out.
REQ-009 SHALL have disp_on  output  1; charge_pump_en  output  1; mux_ratio  output  6; disp_offset  output  6; start_line  output  6; addr_mode  output  2: decoded configuration.
REQ-010 SHALL have data_byte  output  8, data_valid  output  1: received display data, valid pulse.
REQ-011 SHALL have cmd_byte  output  8, cmd_valid  output  1, cmd_err  output  1: last command/parameter byte, accept pulse, reject pulse.

Function
REQ-012 cs_n, sclk, sdin, dc, res_n SHALL each pass through a SYNC_STAGES flop synchronizer; all logic uses only synchronized copies.
REQ-013 Receiver SHALL sample sdin on each detected sclk rising edge while cs_n low; host guarantees sclk high and low each >= SYNC_STAGES+1 clk periods.
REQ-014 3-bit bit counter SHALL increment per sampled bit; the 8th bit completes a byte, dc sampled with that bit, counter wraps to 0.
REQ-015 cs_n high SHALL clear bit counter and discard any partial byte, no pulse; decoder state SHALL be retained across cs_n toggles (one byte per cs_n frame is legal).
REQ-016 Completed byte with dc=1 SHALL drive data_byte and pulse data_valid for exactly one clk, on the cycle after the 8th-edge detection.
REQ-017 Completed byte with dc=0 SHALL go to decoder FSM, states IDLE and PARAM (PARAM holds the pending opcode).
REQ-018 IDLE: AE -> disp_on=0; AF -> disp_on=1; 40-7F -> start_line=byte[5:0]; these pulse cmd_valid, stay IDLE.
REQ-019 IDLE: A8, D3, 8D, 20 SHALL pulse cmd_valid, latch opcode, go to PARAM.
REQ-020 PARAM: A8 -> mux_ratio=byte[5:0] if byte[5:0] >= 15, else unchanged and cmd_err; D3 -> disp_offset=byte[5:0]; 8D -> charge_pump_en=byte[2]; 20 -> addr_mode=byte[1:0] unless 3 (unchanged, cmd_err); then IDLE.
REQ-021 Any other IDLE opcode SHALL pulse cmd_err, no register change, stay IDLE.
REQ-022 dc=1 byte while in PARAM SHALL be delivered as data and SHALL NOT consume the pending parameter.
REQ-023 cmd_byte SHALL update with every dc=0 byte; cmd_valid and cmd_err mutually exclusive, one-cycle pulses, same timing as data_valid.
REQ-024 Synchronized res_n low SHALL restore all REQ-025 values synchronously, overriding a byte completing in the same cycle.

Reset
REQ-025 rst_n low SHALL force: disp_on 0, charge_pump_en 0, mux_ratio 63, disp_offset 0, start_line 0, addr_mode 2, data_byte 0, cmd_byte 0, all pulses 0, sdout 0, FSM IDLE, bit counter 0, synchronizers to idle (cs_n/sclk/res_n high-equivalent where applicable, others 0).
REQ-026 Reset mid-byte SHALL discard the partial byte; no pulse follows release.

Configuration
REQ-027 OLED_CMD_RX_ECHO_EN defined: sdout SHALL shift out, MSB first, the previous completed byte, updating on each detected sclk falling edge while cs_n low; first bit present after cs_n falls.
REQ-028 OLED_CMD_RX_ECHO_EN undefined: sdout SHALL be constant 0, no echo register synthesized.

Verification
REQ-029 Commands AE A8 3F D3 00 40 8D 14 20 00 AF, one per cs_n frame -> disp_on 1, mux_ratio 63, disp_offset 0, start_line 0, charge_pump_en 1, addr_mode 0, 11 cmd_valid, 0 cmd_err.
REQ-030 cs_n high after 5 bits of 0xFF, then full 0xA5 dc=1 -> one data_valid, data_byte 0xA5.
REQ-031 A8 then 0x05 -> cmd_err once, mux_ratio stays 63; then 0x20 param 0x03 -> cmd_err, addr_mode unchanged.
REQ-032 8D, data 0x3C (dc=1), then 0x10 (dc=0) -> data_valid 0x3C, charge_pump_en 0.
REQ-033 rst_n or res_n pulsed after AF and 4 bits of next byte -> disp_on 0, no pulses, next full byte decodes normally.
REQ-034 With OLED_CMD_RX_ECHO_EN: send 0x5A then 0xC3 -> sdout during second byte reads 0x5A; without macro sdout stays 0.
